cam_capture_ctrl: RTL

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

---
 rtl/cam_capture_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// cam_capture_ctrl - DVP sensor frame capture controller, N-frame burst. Rev 1.0
// Optional line/frame length check: define CAM_CAPTURE_FRAME_CHECK_EN
// ============================================================================
module cam_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DW       = 8,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          cmos_pclk,
  input  logic          rst,
  input  logic          cmos_vsync,
  input  logic          cmos_href,
  input  logic [DW-1:0] cam_y,
  input  logic          start,
  input  logic [7:0]    nframes,
  output logic          busy,
  output logic          done,
  input  logic          abort,
  output logic          pix_valid,
  output logic [DW-1:0] pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic          frame_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  logic [1:0]    r_state;
  logic          r_vs, r_hr, r_vs_d, r_hr_d;
  logic [DW-1:0] r_y;
  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic [8:0]    r_frame_cnt;
  logic [8:0]    r_target;

  logic w_vs_rise, w_vs_fall, w_hr_fall, w_emit, w_last_frame;

  assign w_vs_rise    = r_vs & ~r_vs_d;
  assign w_vs_fall    = ~r_vs & r_vs_d;
  assign w_hr_fall    = ~r_hr & r_hr_d;
  // A pixel coinciding with the closing vsync edge belongs to no frame
  assign w_emit       = (r_state == S_CAPTURE) & r_hr & ~w_vs_rise & ~abort;
  assign w_last_frame = ((r_frame_cnt + 9'd1) == r_target);

  assign busy = (r_state == S_ARM) | (r_state == S_CAPTURE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      r_vs   <= 1'b0;
      r_hr   <= 1'b0;
      r_vs_d <= 1'b0;
      r_hr_d <= 1'b0;
      r_y    <= '0;
    end else begin
      r_vs   <= cmos_vsync;
      r_hr   <= cmos_href;
      r_y    <= cam_y;
      r_vs_d <= r_vs;
      r_hr_d <= r_hr;
    end
  end

  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_target    <= '0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_ARM;
            r_frame_cnt <= '0;
            r_target    <= (nframes == 8'd0) ? 9'd256 : {1'b0, nframes};
          end
        end
        S_ARM: begin
          if (abort) begin
            r_state <= S_DONE;
          end else if (w_vs_fall) begin
            r_state <= S_CAPTURE;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            r_state <= S_DONE;
          end else if (w_vs_rise) begin
            r_frame_cnt <= r_frame_cnt + 9'd1;
            r_state     <= w_last_frame ? S_DONE : S_ARM;
          end else if (w_hr_fall) begin
            r_col <= '0;
            if (r_row != Y_MAX) r_row <= r_row + YW'(1);
          end else if (w_emit && (r_col != X_MAX)) begin
            r_col <= r_col + XW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_valid <= w_emit;
      sof       <= w_emit & (r_col == '0) & (r_row == '0);
      // Raw href is the next registered sample: low there means this pixel closes the line
      eol       <= w_emit & ~cmos_href;
      if (w_emit) begin
        pix_data <= r_y;
        pix_x    <= r_col;
        pix_y    <= r_row;
      end
    end
  end

`ifdef CAM_CAPTURE_FRAME_CHECK_EN
  logic r_frame_err;

  // pix_x/pix_y still hold the last emitted pixel when the line/frame edge is seen
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_frame_err <= 1'b0;
    end else if ((r_state == S_CAPTURE) && !abort) begin
      if (w_hr_fall && (pix_x != X_MAX)) r_frame_err <= 1'b1;
      if (w_vs_rise && (pix_y != Y_MAX)) r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire
